data_memory_stage: RTL and testbench

DATA_MEMORY_STAGE -- requirements
Module: data_memory_stage

---
 rtl/cpu_pkg.sv | 18 +
 rtl/data_memory_stage_if.sv | 39 +++
 rtl/dm_ram.sv | 27 ++
 rtl/data_memory_stage.sv | 143 ++++++++++++++
 tb/tb_data_memory_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, DM-stage FSM encoding, latency bounds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  // Bounds on the number of cycles a load/store may occupy the stage
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dm_state_t;

endpackage

// File: rtl/data_memory_stage_if.sv
// EX/DM -> DM/WB boundary bundle for the data memory stage.
// Latency: n/a (wiring only).
// Backpressure: stall_out holds the upstream EX/DM register.
interface data_memory_stage_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] Mem_address;
  logic [WORD_W-1:0] Write_data_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [REG_W-1:0]  rd_in_dm;
  logic              reg_write_in;
  logic              mem_to_reg_in;

  logic              stall_out;
  logic [WORD_W-1:0] read_data_out;
  logic [WORD_W-1:0] alu_result_out;
  logic [REG_W-1:0]  rd_out_dm_wb;
  logic              reg_write_out_dm_wb;
  logic              mem_to_reg_out_dm_wb;
  logic              mem_fault_out;

  // Upstream pipeline side: drives requests, sees stall and results
  modport master (
    output Mem_address, Write_data_in, mem_read_in, mem_write_in,
           rd_in_dm, reg_write_in, mem_to_reg_in,
    input  stall_out, read_data_out, alu_result_out, rd_out_dm_wb,
           reg_write_out_dm_wb, mem_to_reg_out_dm_wb, mem_fault_out
  );

  // Data memory stage side
  modport slave (
    input  Mem_address, Write_data_in, mem_read_in, mem_write_in,
           rd_in_dm, reg_write_in, mem_to_reg_in,
    output stall_out, read_data_out, alu_result_out, rd_out_dm_wb,
           reg_write_out_dm_wb, mem_to_reg_out_dm_wb, mem_fault_out
  );

endinterface

// File: rtl/dm_ram.sv
// Word-addressed data memory array; contents are never reset.
// Latency: write lands at the clock edge, read is combinational from i_idx.
// Backpressure: none; the caller qualifies i_we and samples o_rdata.
module dm_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  // Read port; the stage registers this value only in the completion cycle
  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_stage.sv
// Data memory stage: each load/store occupies LATENCY cycles, then results are registered toward DM/WB.
// Latency: LATENCY cycles per memory op, 1 cycle for non-memory ops.
// Backpressure: stall_out is high for the first LATENCY-1 cycles of a memory op; upstream must hold inputs.
// Optional: DM_MISALIGN_CHECK_EN turns misaligned accesses into faulting no-ops.
module data_memory_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  data_memory_stage_if.slave dm
);

  localparam int IDX_W = $clog2(DEPTH);
  // WAIT counts down to zero; the op completes on the edge leaving cnt == 0
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
  localparam bit MULTI_CYCLE = (LATENCY > 1);

  dm_state_t r_state;
  logic [2:0] r_cnt;

  logic [WORD_W-1:0] r_read_data;
  logic [WORD_W-1:0] r_alu_result;
  logic [REG_W-1:0]  r_rd;
  logic              r_reg_write;
  logic              r_mem_to_reg;

  logic              w_req;
  logic              w_complete;
  logic              w_misalign;
  logic              w_store;
  logic              w_load;
  logic              w_we;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_rdata;

  assign w_req = dm.mem_read_in | dm.mem_write_in;
  // Upper address bits are dropped so the word index wraps modulo DEPTH
  assign w_idx = dm.Mem_address[IDX_W+1:2];

`ifdef DM_MISALIGN_CHECK_EN
  assign w_misalign = w_req && (dm.Mem_address[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Read+write together counts as a store; a misaligned op does neither
  assign w_store = dm.mem_write_in & ~w_misalign;
  assign w_load  = dm.mem_read_in & ~dm.mem_write_in & ~w_misalign;

  // Decide whether the current cycle is the last one of the operation
  always_comb begin
    w_complete = 1'b0;
    case (r_state)
      IDLE:    w_complete = !w_req || !MULTI_CYCLE;
      WAIT:    w_complete = (r_cnt == 3'd0);
      default: w_complete = 1'b0;
    endcase
  end

  assign dm.stall_out = !reset &&
                        (((r_state == IDLE) && w_req && MULTI_CYCLE) ||
                         ((r_state == WAIT) && (r_cnt != 3'd0)));

  // Gated by reset so an aborted op never reaches the array
  assign w_we = w_complete & w_store & ~reset;

  dm_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dm_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (dm.Write_data_in),
    .o_rdata (w_rdata)
  );

  // Occupancy FSM: enter WAIT for multi-cycle ops, count down, return to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && MULTI_CYCLE) begin
            r_state <= WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
          else               r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // DM/WB output registers, loaded only on completion and held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_complete) begin
      r_read_data  <= w_load ? w_rdata : '0;
      r_alu_result <= dm.Mem_address;
      r_rd         <= dm.rd_in_dm;
      r_reg_write  <= dm.reg_write_in & ~w_misalign;
      r_mem_to_reg <= dm.mem_to_reg_in;
    end
  end

`ifdef DM_MISALIGN_CHECK_EN
  logic r_fault;

  // Fault flag is a single-cycle pulse following a misaligned completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fault <= 1'b0;
    else       r_fault <= w_complete & w_misalign;
  end

  assign dm.mem_fault_out = r_fault;
`else
  assign dm.mem_fault_out = 1'b0;
`endif

  assign dm.read_data_out        = r_read_data;
  assign dm.alu_result_out       = r_alu_result;
  assign dm.rd_out_dm_wb         = r_rd;
  assign dm.reg_write_out_dm_wb  = r_reg_write;
  assign dm.mem_to_reg_out_dm_wb = r_mem_to_reg;

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: one instance at LATENCY=2, one at LATENCY=4.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
// Both misalign-check configurations are covered through the DM_MISALIGN_CHECK_EN macro.
module tb_data_memory_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_memory_stage_if if_a ();
  data_memory_stage_if if_b ();

  data_memory_stage #(.DEPTH(256), .LATENCY(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .dm    (if_a.slave)
  );

  data_memory_stage #(.DEPTH(256), .LATENCY(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .dm    (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic rw, input logic m2r);
    if_a.mem_read_in   = rd_en;
    if_a.mem_write_in  = wr_en;
    if_a.Mem_address   = addr;
    if_a.Write_data_in = wdata;
    if_a.rd_in_dm      = rd;
    if_a.reg_write_in  = rw;
    if_a.mem_to_reg_in = m2r;
  endtask

  task automatic drive_b(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic rw, input logic m2r);
    if_b.mem_read_in   = rd_en;
    if_b.mem_write_in  = wr_en;
    if_b.Mem_address   = addr;
    if_b.Write_data_in = wdata;
    if_b.rd_in_dm      = rd;
    if_b.reg_write_in  = rw;
    if_b.mem_to_reg_in = m2r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Reset state, checked before any clock edge
    #3;
    chk("rst_stall",     {31'd0, if_a.stall_out}, 32'd0);
    chk("rst_read_data", if_a.read_data_out, 32'd0);
    chk("rst_alu",       if_a.alu_result_out, 32'd0);
    chk("rst_rd",        {27'd0, if_a.rd_out_dm_wb}, 32'd0);
    chk("rst_regw",      {31'd0, if_a.reg_write_out_dm_wb}, 32'd0);
    chk("rst_fault",     {31'd0, if_a.mem_fault_out}, 32'd0);

    // Non-memory op: no stall, one edge to results
    tick();
    reset = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b0);
    #1;
    chk("nomem_stall", {31'd0, if_a.stall_out}, 32'd0);
    tick();
    chk("nomem_alu",   if_a.alu_result_out, 32'h0000_1234);
    chk("nomem_rdata", if_a.read_data_out, 32'd0);
    chk("nomem_regw",  {31'd0, if_a.reg_write_out_dm_wb}, 32'd1);
    chk("nomem_rd",    {27'd0, if_a.rd_out_dm_wb}, 32'd3);

    // LATENCY=2 store 0xDEADBEEF to 0x40: stall one cycle, outputs held while waiting
    drive_a(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    #1;
    chk("st_stall_c1", {31'd0, if_a.stall_out}, 32'd1);
    tick();
    chk("st_stall_c2", {31'd0, if_a.stall_out}, 32'd0);
    chk("st_hold_alu", if_a.alu_result_out, 32'h0000_1234);
    tick();
    chk("st_done_alu", if_a.alu_result_out, 32'h0000_0040);
    chk("st_rdata",    if_a.read_data_out, 32'd0);
    chk("st_regw",     {31'd0, if_a.reg_write_out_dm_wb}, 32'd0);

    // Load 0x40 with rd=7
    drive_a(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1);
    #1;
    chk("ld_stall_c1", {31'd0, if_a.stall_out}, 32'd1);
    tick();
    chk("ld_stall_c2", {31'd0, if_a.stall_out}, 32'd0);
    tick();
    chk("ld_rdata", if_a.read_data_out, 32'hDEAD_BEEF);
    chk("ld_rd",    {27'd0, if_a.rd_out_dm_wb}, 32'd7);
    chk("ld_m2r",   {31'd0, if_a.mem_to_reg_out_dm_wb}, 32'd1);

    // Wrap: 0x400 maps to word 0 when DEPTH=256
    drive_a(1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    drive_a(1'b1, 1'b0, 32'h0000_0000, 32'h0, 5'd4, 1'b1, 1'b1);
    tick(); tick();
    chk("wrap_rdata", if_a.read_data_out, 32'hCAFE_F00D);

    // Read and write both set: behaves as a store, read data zero
    drive_a(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0077, 5'd5, 1'b0, 1'b0);
    tick(); tick();
    chk("rw_rdata", if_a.read_data_out, 32'd0);
    drive_a(1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd5, 1'b1, 1'b1);
    tick(); tick();
    chk("rw_readback", if_a.read_data_out, 32'h0000_0077);

    // Reset mid-WAIT of a store to 0x10 must not write
    drive_a(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    drive_a(1'b0, 1'b1, 32'h0000_0010, 32'h5A5A_5A5A, 5'd2, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_stall", {31'd0, if_a.stall_out}, 32'd0);
    chk("abort_alu",   if_a.alu_result_out, 32'd0);
    chk("abort_rdata", if_a.read_data_out, 32'd0);
    chk("abort_rd",    {27'd0, if_a.rd_out_dm_wb}, 32'd0);
    tick();
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd1, 1'b1, 1'b1);
    #1;
    chk("abort_idle_stall", {31'd0, if_a.stall_out}, 32'd1);
    tick(); tick();
    chk("abort_nowrite", if_a.read_data_out, 32'hA5A5_A5A5);

    // LATENCY=4 on the second instance
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    drive_b(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    drive_b(1'b1, 1'b0, 32'h0000_0008, 32'h0, 5'd9, 1'b1, 1'b1);
    #1;
    chk("l4_stall_c1", {31'd0, if_b.stall_out}, 32'd1);
    tick();
    chk("l4_stall_c2", {31'd0, if_b.stall_out}, 32'd1);
    tick();
    chk("l4_stall_c3", {31'd0, if_b.stall_out}, 32'd1);
    tick();
    chk("l4_stall_c4", {31'd0, if_b.stall_out}, 32'd0);
    chk("l4_rd_held",  {27'd0, if_b.rd_out_dm_wb}, 32'd0);
    tick();
    chk("l4_rdata", if_b.read_data_out, 32'h1234_5678);
    chk("l4_rd",    {27'd0, if_b.rd_out_dm_wb}, 32'd9);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Misaligned store to 0x41
    drive_a(1'b0, 1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b0);
    tick(); tick();
`ifdef DM_MISALIGN_CHECK_EN
    chk("mis_fault",  {31'd0, if_a.mem_fault_out}, 32'd1);
    chk("mis_regw",   {31'd0, if_a.reg_write_out_dm_wb}, 32'd0);
    chk("mis_rdata",  if_a.read_data_out, 32'd0);
    drive_a(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1);
    tick();
    chk("mis_fault_pulse", {31'd0, if_a.mem_fault_out}, 32'd0);
    tick();
    chk("mis_nowrite", if_a.read_data_out, 32'hDEAD_BEEF);
`else
    chk("mis_fault",  {31'd0, if_a.mem_fault_out}, 32'd0);
    chk("mis_regw",   {31'd0, if_a.reg_write_out_dm_wb}, 32'd1);
    drive_a(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1);
    tick(); tick();
    chk("mis_lowbits_ignored", if_a.read_data_out, 32'hFFFF_FFFF);
    chk("mis_fault_after",     {31'd0, if_a.mem_fault_out}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
